mw_memory_stage: RTL and testbench

- MEM stage of the 5-stage CPU; consumes the buffered EX/MEM signals and drives the data-memory req/ack port.
- Stalls upstream stages while a load/store is outstanding and resolves branches (pc_src).
- Registers the MEM/WB bundle (read data, ALU result, destination, writeback controls) for the WB stage.

---
 rtl/mw_memory_stage_pkg.sv | 20 ++
 rtl/mw_pipeline_register.sv | 26 ++
 rtl/mw_memory_stage.sv | 131 +++++++++++++
 tb/tb_mw_memory_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mw_memory_stage_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, datapath widths and the MEM/WB bundle.
package mw_memory_stage_pkg;

   localparam int WORD_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic [WORD_W-1:0]     read_data;
      logic [WORD_W-1:0]     alu_result;
      logic [REG_ADDR_W-1:0] write_reg_addr;
      logic                  mem_reg;
      logic                  reg_write;
   } memwb_t;

endpackage

// File: rtl/mw_pipeline_register.sv
// MEM/WB pipeline flops. A bubble kills the writeback enable and holds every other field.
module mw_pipeline_register
   import mw_memory_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   bubble_i,
   input  memwb_t d_i,
   output memwb_t q_o
);

   memwb_t q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (bubble_i) begin
         q_q.reg_write <= 1'b0;
      end else begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/mw_memory_stage.sv
// MEM stage: drives the data-memory req/ack port, stalls upstream while an access is
// outstanding, abandons it after TIMEOUT wait cycles and registers the MEM/WB bundle.
module mw_memory_stage
   import mw_memory_stage_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WORD_W-1:0]     alu_result,
   input  logic                  alu_zero,
   input  logic [WORD_W-1:0]     jump_result,
   input  logic [REG_ADDR_W-1:0] write_reg_addr,
   input  logic [WORD_W-1:0]     store_data,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  mem_reg,
   input  logic                  branch,
   input  logic                  reg_write,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [WORD_W-1:0]     dmem_addr,
   output logic [WORD_W-1:0]     dmem_wdata,
   input  logic [WORD_W-1:0]     dmem_rdata,
   input  logic                  dmem_ack,
   output logic                  stall,
   output logic                  pc_src,
   output logic [WORD_W-1:0]     branch_target,
   output logic                  addr_error,
   output logic                  bus_error,
   output logic [WORD_W-1:0]     read_data_buffered,
   output logic [WORD_W-1:0]     alu_result_buffered,
   output logic [REG_ADDR_W-1:0] write_reg_addr_buffered,
   output logic                  mem_reg_buffered,
   output logic                  reg_write_buffered,
   output mem_state_e            state_dbg
);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             addr_error_q, bus_error_q;
   logic             memop, aligned, timeout_hit, complete, abandon, misaligned, bubble;
   memwb_t           memwb_d, memwb_q;

   assign memop       = mem_read | mem_write;
   assign aligned     = (alu_result[1:0] == 2'b00);
   assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT));

   // rst_n gating drops the request/stall/branch immediately, even with inputs still asserted.
   assign dmem_req   = rst_n & (((state_q == IDLE) & memop & aligned) | (state_q == WAIT));
   assign stall      = dmem_req & ~dmem_ack & ~timeout_hit;
   assign complete   = dmem_req & dmem_ack;
   assign abandon    = timeout_hit & ~dmem_ack;
   assign misaligned = (state_q == IDLE) & memop & ~aligned;

   assign dmem_we       = mem_write;
   assign dmem_addr     = alu_result;
   assign dmem_wdata    = store_data;
   assign pc_src        = rst_n & branch & alu_zero & ~stall;
   assign branch_target = jump_result;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (memop && aligned && !dmem_ack) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT: begin
            if (dmem_ack || timeout_hit) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_error_q <= 1'b0;
         bus_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_error_q <= misaligned;
         bus_error_q  <= abandon;
      end
   end

   // Write wins when both mem_read and mem_write are set, so only a pure read returns data.
   always_comb begin
      memwb_d                = '0;
      memwb_d.read_data      = (complete && mem_read && !mem_write) ? dmem_rdata : '0;
      memwb_d.alu_result     = alu_result;
      memwb_d.write_reg_addr = write_reg_addr;
      memwb_d.mem_reg        = mem_reg;
      memwb_d.reg_write      = reg_write;
   end

   assign bubble = stall | misaligned | abandon;

   mw_pipeline_register u_memwb (
      .clk      (clk),
      .rst_n    (rst_n),
      .bubble_i (bubble),
      .d_i      (memwb_d),
      .q_o      (memwb_q)
   );

   assign read_data_buffered      = memwb_q.read_data;
   assign alu_result_buffered     = memwb_q.alu_result;
   assign write_reg_addr_buffered = memwb_q.write_reg_addr;
   assign mem_reg_buffered        = memwb_q.mem_reg;
   assign reg_write_buffered      = memwb_q.reg_write;
   assign addr_error              = addr_error_q;
   assign bus_error               = bus_error_q;
   assign state_dbg               = state_q;

endmodule

// File: tb/tb_mw_memory_stage.sv
// Bench for mw_memory_stage: directed scenarios plus random instructions against a
// transaction-level model of stall length, completion and MEM/WB contents.
module tb_mw_memory_stage;
   import mw_memory_stage_pkg::*;

   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 4;
   localparam int NEVER   = 99;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] alu_result, jump_result, store_data, dmem_rdata;
   logic        alu_zero, mem_read, mem_write, mem_reg, branch, reg_write, dmem_ack;
   logic [4:0]  write_reg_addr;
   logic        dmem_req, dmem_we, stall, pc_src, addr_error, bus_error;
   logic [31:0] dmem_addr, dmem_wdata, branch_target, read_data_buffered, alu_result_buffered;
   logic [4:0]  write_reg_addr_buffered;
   logic        mem_reg_buffered, reg_write_buffered;
   mem_state_e  state_dbg;

   int checks = 0;
   int errors = 0;

   // Expected MEM/WB contents
   logic [31:0] m_rd, m_alu;
   logic [4:0]  m_wra;
   logic        m_mreg, m_rw;

   mw_memory_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .alu_result              (alu_result),
      .alu_zero                (alu_zero),
      .jump_result             (jump_result),
      .write_reg_addr          (write_reg_addr),
      .store_data              (store_data),
      .mem_read                (mem_read),
      .mem_write               (mem_write),
      .mem_reg                 (mem_reg),
      .branch                  (branch),
      .reg_write               (reg_write),
      .dmem_req                (dmem_req),
      .dmem_we                 (dmem_we),
      .dmem_addr               (dmem_addr),
      .dmem_wdata              (dmem_wdata),
      .dmem_rdata              (dmem_rdata),
      .dmem_ack                (dmem_ack),
      .stall                   (stall),
      .pc_src                  (pc_src),
      .branch_target           (branch_target),
      .addr_error              (addr_error),
      .bus_error               (bus_error),
      .read_data_buffered      (read_data_buffered),
      .alu_result_buffered     (alu_result_buffered),
      .write_reg_addr_buffered (write_reg_addr_buffered),
      .mem_reg_buffered        (mem_reg_buffered),
      .reg_write_buffered      (reg_write_buffered),
      .state_dbg               (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_nop();
      alu_result = '0; alu_zero = 1'b0; jump_result = '0; write_reg_addr = '0;
      store_data = '0; mem_read = 1'b0; mem_write = 1'b0; mem_reg = 1'b0;
      branch = 1'b0; reg_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
   endtask

   task automatic check_memwb(input string tag);
      chk({tag, ".read_data"}, read_data_buffered, m_rd);
      chk({tag, ".alu_result"}, alu_result_buffered, m_alu);
      chk({tag, ".wr_addr"}, 32'(write_reg_addr_buffered), 32'(m_wra));
      chk({tag, ".mem_reg"}, 32'(mem_reg_buffered), 32'(m_mreg));
      chk({tag, ".reg_write"}, 32'(reg_write_buffered), 32'(m_rw));
   endtask

   // Called just after a posedge; returns just after the posedge that retires the instruction.
   // ack_at: wait cycle (0 = same cycle as request) in which memory acknowledges.
   task automatic run_instr(input string tag, input logic [31:0] alu, input logic zero,
                            input logic [31:0] jt, input logic [4:0] wra, input logic [31:0] sd,
                            input logic rd, input logic wr, input logic mreg, input logic br,
                            input logic rw, input int ack_at);
      logic        memop, aligned, done;
      int          wait_n;
      logic [31:0] rdata_v;
      logic        exp_stall;
      memop   = rd | wr;
      aligned = (alu % 4) == 0;
      done    = memop && aligned && (ack_at <= TIMEOUT);
      wait_n  = (memop && aligned) ? ((ack_at <= TIMEOUT) ? ack_at : TIMEOUT) : 0;
      rdata_v = $urandom;
      alu_result = alu; alu_zero = zero; jump_result = jt; write_reg_addr = wra;
      store_data = sd; mem_read = rd; mem_write = wr; mem_reg = mreg; branch = br;
      reg_write = rw;
      for (int cyc = 0; cyc <= TIMEOUT + 2; cyc++) begin
         dmem_ack   = memop && aligned && (cyc == ack_at);
         dmem_rdata = dmem_ack ? rdata_v : $urandom;
         @(negedge clk);
         exp_stall = (cyc < wait_n);
         chk({tag, ".dmem_req"}, 32'(dmem_req), 32'(memop && aligned));
         chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
         chk({tag, ".pc_src"}, 32'(pc_src), 32'(br && zero && !exp_stall));
         chk({tag, ".branch_target"}, branch_target, jt);
         chk({tag, ".dmem_addr"}, dmem_addr, alu);
         chk({tag, ".dmem_wdata"}, dmem_wdata, sd);
         chk({tag, ".dmem_we"}, 32'(dmem_we), 32'(wr));
         if (cyc > 0) chk({tag, ".bubble_rw"}, 32'(reg_write_buffered), 32'(0));
         if (!stall) break;
         @(posedge clk); #1;
      end
      chk({tag, ".stall_bound"}, 32'(stall), 32'(0));
      @(posedge clk); #1;
      if (!memop || done) begin
         m_rd   = (done && rd && !wr) ? rdata_v : 32'h0;
         m_alu  = alu;
         m_wra  = wra;
         m_mreg = mreg;
         m_rw   = rw;
      end else begin
         m_rw = 1'b0;
      end
      check_memwb(tag);
      chk({tag, ".addr_error"}, 32'(addr_error), 32'(memop && !aligned));
      chk({tag, ".bus_error"}, 32'(bus_error), 32'(memop && aligned && !done));
      chk({tag, ".state_idle"}, 32'(state_dbg), 32'(IDLE));
   endtask

   initial begin
      int          kind, ack_at;
      logic [31:0] a;
      rst_n = 1'b0;
      drive_nop();
      m_rd = '0; m_alu = '0; m_wra = '0; m_mreg = 1'b0; m_rw = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_memwb("reset");
      chk("reset.addr_error", 32'(addr_error), 32'(0));
      chk("reset.bus_error", 32'(bus_error), 32'(0));
      chk("reset.dmem_req", 32'(dmem_req), 32'(0));
      chk("reset.state", 32'(state_dbg), 32'(IDLE));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_instr("zw_load", 32'h40, 1'b0, 32'h0, 5'd8, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      run_instr("store3", 32'h100, 1'b0, 32'h0, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
      run_instr("timeout", 32'h80, 1'b0, 32'h0, 5'd9, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, NEVER);
      run_instr("after_to", 32'h55, 1'b0, 32'h0, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      run_instr("misalign", 32'h42, 1'b0, 32'h0, 5'd4, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      run_instr("br_taken", 32'h0, 1'b1, 32'h200, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      run_instr("br_not", 32'h7, 1'b0, 32'h200, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      run_instr("ack_at_to", 32'hC0, 1'b0, 32'h0, 5'd12, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, TIMEOUT);
      run_instr("rd_and_wr", 32'hC4, 1'b0, 32'h0, 5'd13, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);

      // Reset during the second wait cycle of a load
      alu_result = 32'h300; mem_read = 1'b1; reg_write = 1'b1; write_reg_addr = 5'd5;
      dmem_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      branch = 1'b1; alu_zero = 1'b1;
      rst_n = 1'b0;
      #1;
      m_rd = '0; m_alu = '0; m_wra = '0; m_mreg = 1'b0; m_rw = 1'b0;
      chk("rst_mid.dmem_req", 32'(dmem_req), 32'(0));
      chk("rst_mid.stall", 32'(stall), 32'(0));
      chk("rst_mid.pc_src", 32'(pc_src), 32'(0));
      chk("rst_mid.state", 32'(state_dbg), 32'(IDLE));
      check_memwb("rst_mid");
      drive_nop();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_instr("post_rst", 32'h44, 1'b0, 32'h0, 5'd6, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2);

      for (int i = 0; i < 60; i++) begin
         kind   = $urandom_range(0, 9);
         ack_at = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 6);
         a      = $urandom;
         case (kind)
            0, 1, 2: run_instr("rnd_alu", a, 1'($urandom), $urandom, 5'($urandom), $urandom,
                               1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 0);
            3, 4, 5: run_instr("rnd_load", {a[31:2], 2'b00}, 1'b0, $urandom, 5'($urandom), $urandom,
                               1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ack_at);
            6, 7:    run_instr("rnd_store", {a[31:2], 2'b00}, 1'($urandom), $urandom, 5'($urandom),
                               $urandom, 1'b0, 1'b1, 1'b0, 1'($urandom), 1'b0, ack_at);
            default: run_instr("rnd_misal", {a[31:2], 2'($urandom_range(1, 3))}, 1'b0, $urandom,
                               5'($urandom), $urandom, 1'($urandom), 1'b1, 1'b1, 1'b0, 1'b1, ack_at);
         endcase
      end

      drive_nop();
      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
